// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with branch/jump/return select
// Holds the architectural PC and a circular return-address stack for call/return.
module pc_unit #(
   parameter int WIDTH     = 32,
   parameter int STEP      = 4,
   parameter int RESET_PC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_step,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ret_underflow,
   output logic             misaligned
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
   logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
   logic             ret_underflow_q, ret_underflow_d;
   logic             push;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

   assign pc_plus_step  = pc_q + STEP_W;
   assign pc            = pc_q;
   assign ras_empty     = (ras_cnt_q == '0);
   assign ras_full      = (ras_cnt_q == FULL_CNT);
   assign ret_underflow = ret_underflow_q;
   assign misaligned    = ((pc_q & (STEP_W - WIDTH'(1))) != '0);

   always_comb begin
      pc_d            = pc_q + STEP_W;
      ras_ptr_d       = ras_ptr_q;
      ras_cnt_d       = ras_cnt_q;
      ret_underflow_d = 1'b0;
      push            = 1'b0;
      if (stall) begin
         pc_d = pc_q;
      end else if (ret) begin
         if (ras_empty) begin
            ret_underflow_d = 1'b1;
         end else begin
            pc_d      = ras_mem[ras_ptr_q];
            ras_ptr_d = ras_ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
         end
      end else if (jump) begin
         pc_d = jump_target;
         if (call) begin
            // Pushing onto a full stack wraps the pointer over the oldest entry.
            push      = 1'b1;
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (!ras_full) ras_cnt_d = ras_cnt_q + CNT_W'(1);
         end
      end else if (branch_taken) begin
         pc_d = pc_q + branch_offset;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q            <= RESET_W;
         ras_ptr_q       <= '0;
         ras_cnt_q       <= '0;
         ret_underflow_q <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ras_ptr_q       <= ras_ptr_d;
         ras_cnt_q       <= ras_cnt_d;
         ret_underflow_q <= ret_underflow_d;
      end
   end

   // Entry contents need no reset; count and pointer define validity.
   always_ff @(posedge clk) begin
      if (push && !reset) ras_mem[ras_ptr_d] <= pc_plus_step;
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
// Drives control vectors between edges and checks outputs one time unit after each edge.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch_taken, jump, call, ret;
   logic [31:0] branch_offset, jump_target;
   logic [31:0] pc, pc_plus_step;
   logic        ras_empty, ras_full, ret_underflow, misaligned;

   int n_cmp = 0;
   int n_bad = 0;

   pc_unit #(.WIDTH(32), .STEP(4), .RESET_PC(0), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .call(call), .ret(ret), .pc(pc), .pc_plus_step(pc_plus_step),
      .ras_empty(ras_empty), .ras_full(ras_full), .ret_underflow(ret_underflow),
      .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_ctrl();
      stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
      branch_offset = '0; jump_target = '0;
   endtask

   // One cycle with the given controls; controls cleared afterwards.
   task automatic cyc(input logic s, input logic r, input logic j, input logic c,
                      input logic b, input logic [31:0] tgt, input logic [31:0] off);
      stall = s; ret = r; jump = j; call = c; branch_taken = b;
      jump_target = tgt; branch_offset = off;
      @(posedge clk);
      #1;
      clear_ctrl();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      clear_ctrl();
      reset = 1'b1;
      #12;
      check("rst_pc", pc, 32'h0);
      check("rst_pps", pc_plus_step, 32'h4);
      check("rst_empty", {31'b0, ras_empty}, 32'h1);
      check("rst_full", {31'b0, ras_full}, 32'h0);
      check("rst_uflow", {31'b0, ret_underflow}, 32'h0);
      check("rst_misal", {31'b0, misaligned}, 32'h0);
      reset = 1'b0;

      for (int i = 1; i <= 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         check("seq_pc", pc, 32'(4 * i));
      end
      check("seq_empty", {31'b0, ras_empty}, 32'h1);

      cyc(0, 0, 1, 0, 0, 32'h100, 0);
      check("jmp_100", pc, 32'h100);
      cyc(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF0);
      check("br_back", pc, 32'hF0);
      cyc(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
      check("jmp_top", pc, 32'hFFFF_FFFC);
      check("pps_wrap", pc_plus_step, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("seq_wrap", pc, 32'h0);
      cyc(0, 0, 1, 0, 0, 32'h102, 0);
      check("jmp_mis_pc", pc, 32'h102);
      check("jmp_mis", {31'b0, misaligned}, 32'h1);
      check("mis_pps", pc_plus_step, 32'h106);

      cyc(0, 0, 1, 0, 0, 32'h40, 0);
      check("mis_clear", {31'b0, misaligned}, 32'h0);
      cyc(0, 0, 1, 1, 0, 32'h200, 0);
      check("call_pc", pc, 32'h200);
      check("call_nempty", {31'b0, ras_empty}, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("call_seq", pc, 32'h208);
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("ret_pc", pc, 32'h44);
      check("ret_empty", {31'b0, ras_empty}, 32'h1);

      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 1, 0, 0, 32'(16 * i), 0);
         cyc(0, 0, 1, 1, 0, 32'h1000, 0);
         check("ovf_full", {31'b0, ras_full}, (i >= 4) ? 32'h1 : 32'h0);
      end
      check("ovf_pc", pc, 32'h1000);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 0, 0, 0);
         check("ovf_ret", pc, 32'h54 - 32'(16 * i));
         check("ovf_nfull", {31'b0, ras_full}, 32'h0);
         check("ovf_uf0", {31'b0, ret_underflow}, 32'h0);
      end
      check("ovf_empty", {31'b0, ras_empty}, 32'h1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("uf_pc", pc, 32'h28);
      check("uf_pulse", {31'b0, ret_underflow}, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("uf_drop", {31'b0, ret_underflow}, 32'h0);
      check("uf_seq", pc, 32'h2C);

      cyc(0, 0, 1, 1, 0, 32'h300, 0);
      cyc(0, 0, 1, 1, 0, 32'h400, 0);
      cyc(0, 1, 1, 1, 1, 32'h800, 32'h10);
      check("prio_pc", pc, 32'h304);
      check("prio_nempty", {31'b0, ras_empty}, 32'h0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("prio_ret2", pc, 32'h30);
      check("prio_empty", {31'b0, ras_empty}, 32'h1);

      cyc(0, 0, 1, 1, 0, 32'h500, 0);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 1, 1, 1, 1, 32'h900, 32'h10);
         check("stall_pc", pc, 32'h500);
         check("stall_cnt", {31'b0, ras_empty}, 32'h0);
      end
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("stall_ret", pc, 32'h34);
      check("stall_empty", {31'b0, ras_empty}, 32'h1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      check("uf2_pulse", {31'b0, ret_underflow}, 32'h1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      check("uf2_stall", {31'b0, ret_underflow}, 32'h0);
      check("uf2_pc", pc, 32'h38);

      cyc(0, 0, 1, 1, 0, 32'h600, 0);
      check("ar_call", pc, 32'h600);
      jump = 1; call = 1; jump_target = 32'h700;
      #2;
      reset = 1'b1;
      #1;
      check("ar_pc", pc, 32'h0);
      check("ar_empty", {31'b0, ras_empty}, 32'h1);
      reset = 1'b0;
      clear_ctrl();
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("ar_seq", pc, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor fetch stage. It holds the architectural PC and selects the next PC from four sources: sequential increment, PC-relative branch, absolute jump, or return. A small return-address stack (RAS) supports call/return. It replaces the bare PC adder plus external PC register and mux with one registered block driving the instruction-memory address.

## Interface
Parameters:
- `WIDTH`, 32: PC and address width in bits.
- `STEP`, 4: sequential increment in bytes. Must be a power of two, ≤ 2^(WIDTH-1).
- `RESET_PC`, 0: PC value loaded on reset. Must be a multiple of `STEP`.
- `RAS_DEPTH`, 4: return-address stack entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `stall`, in, 1: hold PC and RAS unchanged.
- `branch_taken`, in, 1: take a PC-relative branch.
- `branch_offset`, in, WIDTH: signed byte offset, two's complement.
- `jump`, in, 1: absolute jump to `jump_target`.
- `jump_target`, in, WIDTH: absolute byte address.
- `call`, in, 1: qualifies `jump`; pushes the return address.
- `ret`, in, 1: pop the RAS and jump to the popped address.
- `pc`, out, WIDTH: current PC (registered).
- `pc_plus_step`, out, WIDTH: `pc + STEP`, combinational, modulo 2^WIDTH.
- `ras_empty`, out, 1: RAS holds 0 entries.
- `ras_full`, out, 1: RAS holds `RAS_DEPTH` entries.
- `ret_underflow`, out, 1: registered one-cycle pulse on a `ret` with an empty RAS.
- `misaligned`, out, 1: combinational; `pc` is not a multiple of `STEP`.

## Operation
- Next-PC priority, evaluated every cycle:
  1. `stall`
  2. `ret`
  3. `jump`
  4. `branch_taken`
  5. sequential
- `stall`=1: `pc`, RAS contents, pointer and count hold. `ret_underflow` goes to 0. All other inputs are ignored.
- `ret` with RAS non-empty: next PC = top entry; pop (count−1).
- `ret` with RAS empty: next PC = `pc + STEP`; no pop; `ret_underflow`=1 the next cycle.
- `ret` wins over `jump`/`call`/`branch_taken` in the same cycle. Those inputs are ignored and nothing is pushed.
- `jump` (no `ret`): next PC = `jump_target`.
- `jump` with `call`=1: additionally push `pc + STEP`.
- `call` without `jump` has no effect.
- `branch_taken` (no `ret`/`jump`): next PC = `pc + branch_offset`.
- Otherwise: next PC = `pc + STEP`.
- Arithmetic: all adds are WIDTH bits, modulo 2^WIDTH, and wrap silently (e.g. `pc` = 0xFFFFFFFC + 4 → 0x00000000).
- `jump_target` and the branch result are not re-aligned. A misaligned value is loaded as-is and flagged by `misaligned`.
- RAS structure: circular buffer with top pointer and count (0..`RAS_DEPTH`).
- Push when full: overwrite the oldest entry (pointer wraps), count stays `RAS_DEPTH`, `ras_full` stays 1.
- After `RAS_DEPTH`+1 pushes, at most `RAS_DEPTH` pops return valid addresses, newest first. The next pop underflows.

## Timing
- Reset values (asynchronous, immediate on `reset`=1):
  - `pc` = `RESET_PC`
  - RAS count = 0 and pointer = 0, so `ras_empty`=1 and `ras_full`=0
  - `ret_underflow` = 0
  - `pc_plus_step` = `RESET_PC + STEP`
  - `misaligned` = 0
- RAS entry contents are don't-care after reset.
- Reset asserted mid-operation discards any pending push/pop. The first update after deassertion uses the normal priority.
- Latency: a control input sampled at edge N determines `pc` after edge N. This is one-cycle redirect, with no bubble inside the block.
- `ras_empty`/`ras_full` reflect the count after the edge. A push and a pop are never both performed in one cycle.
- `misaligned` and `pc_plus_step` are purely combinational from `pc`.

## Test plan
- Reset and sequential: assert `reset`, release, then run 3 cycles with no controls → `pc` = 0, 4, 8, 12; `ras_empty`=1.
- Branch and wrap:
  - From `pc`=0x100, `branch_offset`=0xFFFFFFF0 → `pc`=0xF0.
  - From `pc`=0xFFFFFFFC, sequential → `pc`=0.
  - `jump_target`=0x102 → `pc`=0x102 with `misaligned`=1.
- Call/return: from `pc`=0x40, `jump`+`call` to 0x200 → `pc`=0x200, `ras_empty`=0. Two sequential cycles, then `ret` → `pc`=0x44, `ras_empty`=1.
- RAS overflow/underflow (`RAS_DEPTH`=4):
  - 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_full`=1.
  - 4 rets return 0x54, 0x44, 0x34, 0x24.
  - 5th ret → `pc` = previous `pc`+4 and `ret_underflow`=1 for exactly one cycle.
- Priority/stall:
  - `ret`+`jump`+`call`+`branch_taken` together → return address taken, no push (count drops by 1).
  - `stall` with `jump` and `ret` asserted → `pc` and count unchanged for the stalled cycles.
- Async reset mid-stream: assert `reset` between edges during a call sequence → `pc`=`RESET_PC` immediately (before the next edge), `ras_empty`=1.
